mem_stage_ctrl: RTL and testbench

//  MEM-stage data-memory controller between EX_MEM_REG outputs and MEM_WB_REG inputs.

---
 rtl/mem_stage_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: RAM_CTRL decode, req/ack handshake, big-endian lane steering.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state timeout that aborts with a mem_err pulse.
module mem_stage_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       ex_out,
   input  logic [31:0]       ex_di,
   input  logic [4:0]        ex_rd,
   input  logic              l,
   input  logic              rf_le,
   input  logic [3:0]        ram_ctrl,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              mem_stall,
   output logic [31:0]       mem_out,
   output logic [4:0]        mem_rd,
   output logic              mem_rf_le,
   output logic              mem_misalign,
   output logic              mem_err
);

   // state | meaning
   // IDLE  | no access in flight; pass-through, or launch a RAM access
   // WAIT  | mem_req high, pipeline stalled until ack (or timeout)
   // DONE  | one cycle presenting the result to MEM/WB
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         ldata_q, ldata_d;
   logic [1:0]          size_q, size_d;
   logic [1:0]          off_q, off_d;
   logic                terr_q, terr_d;
   logic                timeout_hit;

   logic                acc_en, acc_rw, misal;
   logic [1:0]          acc_size, acc_off;
   logic [3:0]          st_be;
   logic [31:0]         st_wdata;
   logic [31:0]         ld_steer;

   assign acc_en   = ram_ctrl[3];
   assign acc_rw   = ram_ctrl[2];
   assign acc_size = ram_ctrl[1:0];
   assign acc_off  = ex_out[1:0];
   assign misal    = (acc_size == 2'b11) ||
                     ((acc_size == 2'b01) && acc_off[0]) ||
                     ((acc_size == 2'b10) && (acc_off != 2'b00));

   // Byte lane 0 (offset 0) lives in bits 31:24.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = ex_di;
      if (acc_rw) begin
         case (acc_size)
            2'b00: begin
               st_be    = 4'b1000 >> acc_off;
               st_wdata = {4{ex_di[7:0]}};
            end
            2'b01: begin
               st_be    = acc_off[1] ? 4'b0011 : 4'b1100;
               st_wdata = {2{ex_di[15:0]}};
            end
            default: begin
               st_be    = 4'b1111;
               st_wdata = ex_di;
            end
         endcase
      end
   end

   always_comb begin
      ld_steer = mem_rdata;
      case (size_q)
         2'b00: begin
            case (off_q)
               2'd0:    ld_steer = {24'h0, mem_rdata[31:24]};
               2'd1:    ld_steer = {24'h0, mem_rdata[23:16]};
               2'd2:    ld_steer = {24'h0, mem_rdata[15:8]};
               default: ld_steer = {24'h0, mem_rdata[7:0]};
            endcase
         end
         2'b01:   ld_steer = {16'h0, off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16]};
         default: ld_steer = mem_rdata;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   // Counter is held at zero outside WAIT, so it is clear on every WAIT entry.
   assign cnt_d       = (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
   assign timeout_hit = (state_q == WAIT) && !mem_ack && (cnt_q == 8'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= 8'd0;
      else          cnt_q <= cnt_d;
   end
`else
   assign timeout_hit = 1'b0;

   // TIMEOUT_CYC only has an effect in the timeout build.
   if (TIMEOUT_CYC < 1) begin : g_timeout_unused
   end
`endif

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      ldata_d      = ldata_q;
      size_d       = size_q;
      off_d        = off_q;
      terr_d       = terr_q;
      mem_stall    = 1'b0;
      mem_out      = ex_out;
      mem_rf_le    = rf_le;
      mem_misalign = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc_en) begin
               mem_rf_le = 1'b0;
               if (misal) begin
                  mem_misalign = 1'b1;
                  mem_out      = 32'h0;
               end else begin
                  mem_stall = 1'b1;
                  req_d     = 1'b1;
                  we_d      = acc_rw;
                  addr_d    = {ex_out[ADDR_W-1:2], 2'b00};
                  be_d      = st_be;
                  wdata_d   = st_wdata;
                  size_d    = acc_size;
                  off_d     = acc_off;
                  terr_d    = 1'b0;
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            mem_stall = 1'b1;
            mem_rf_le = 1'b0;
            if (mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               ldata_d = ld_steer;
               state_d = DONE;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               ldata_d = 32'h0;
               terr_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            mem_out   = l ? ldata_q : ex_out;
            mem_rf_le = rf_le && !terr_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0;
         ldata_q <= 32'h0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         ldata_q <= ldata_d;
         size_q  <= size_d;
         off_q   <= off_d;
         terr_q  <= terr_d;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;
   assign mem_rd    = ex_rd;
   assign mem_err   = timeout_hit;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed spec cases plus randomized accesses vs a reference model.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] ex_out, ex_di, mem_rdata;
   logic [4:0]  ex_rd;
   logic        l, rf_le, mem_ack;
   logic [3:0]  ram_ctrl;
   logic        mem_req, mem_we, mem_stall, mem_rf_le, mem_misalign, mem_err;
   logic [7:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_out;
   logic [4:0]  mem_rd;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset_n(reset_n), .ex_out(ex_out), .ex_di(ex_di), .ex_rd(ex_rd),
      .l(l), .rf_le(rf_le), .ram_ctrl(ram_ctrl), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_stall(mem_stall), .mem_out(mem_out), .mem_rd(mem_rd),
      .mem_rf_le(mem_rf_le), .mem_misalign(mem_misalign), .mem_err(mem_err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference model: byte k of a word (k = address offset) is bits [31-8k : 24-8k].
   function automatic bit model_misaligned(input logic [1:0] size, input int off);
      return (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
   endfunction

   function automatic logic [3:0] model_be(input logic rw, input logic [1:0] size, input int off);
      if (!rw) return 4'hF;
      if (size == 2'd0) return 4'((1 << (3 - off)));
      if (size == 2'd1) return (off >= 2) ? 4'h3 : 4'hC;
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] di);
      if (size == 2'd0) return 32'(di[7:0]) * 32'h0101_0101;
      if (size == 2'd1) return 32'(di[15:0]) * 32'h0001_0001;
      return di;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input int off, input logic [31:0] rd);
      if (size == 2'd0) return (rd >> (8 * (3 - off))) & 32'hFF;
      if (size == 2'd1) return (rd >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      return rd;
   endfunction

   // One pipeline op: IDLE cycle, then d WAIT cycles (ack in the d-th), then DONE.
   task automatic run_op(input logic e, input logic rw, input logic [1:0] size,
                         input logic [31:0] exo, input logic [31:0] di, input logic ld,
                         input logic rfle, input logic [4:0] rd, input int d,
                         input logic [31:0] rdata, input logic junk_ack, input string tag);
      int off;
      bit mis;
      logic [31:0] exp_out;
      off = int'(exo[1:0]);
      mis = model_misaligned(size, off);
      @(posedge clk); #1;
      ex_out = exo; ex_di = di; l = ld; rf_le = rfle; ex_rd = rd;
      ram_ctrl = {e, rw, size}; mem_ack = junk_ack; mem_rdata = $urandom;
      @(negedge clk);
      n_cmp++;
      if (!e) begin
         if (mem_out !== exo || mem_rf_le !== rfle || mem_rd !== rd || mem_stall !== 1'b0 ||
             mem_req !== 1'b0 || mem_misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL %s passthru: out=%h rf_le=%b rd=%0d stall=%b req=%b mis=%b, expected out=%h rf_le=%b rd=%0d stall=0 req=0 mis=0",
                     tag, mem_out, mem_rf_le, mem_rd, mem_stall, mem_req, mem_misalign, exo, rfle, rd);
         end
         return;
      end
      if (mis) begin
         if (mem_misalign !== 1'b1 || mem_out !== 32'h0 || mem_rf_le !== 1'b0 ||
             mem_stall !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s misalign: mis=%b out=%h rf_le=%b stall=%b req=%b, expected mis=1 out=0 rf_le=0 stall=0 req=0",
                     tag, mem_misalign, mem_out, mem_rf_le, mem_stall, mem_req);
         end
         @(posedge clk); #1;
         ram_ctrl = 4'h0; mem_ack = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (mem_req !== 1'b0 || mem_misalign !== 1'b0 || mem_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_misalign: req=%b mis=%b stall=%b, expected all 0",
                     tag, mem_req, mem_misalign, mem_stall);
         end
         return;
      end
      if (mem_stall !== 1'b1 || mem_rf_le !== 1'b0 || mem_req !== 1'b0 || mem_misalign !== 1'b0) begin
         n_bad++;
         $display("FAIL %s issue: stall=%b rf_le=%b req=%b mis=%b, expected stall=1 rf_le=0 req=0 mis=0",
                  tag, mem_stall, mem_rf_le, mem_req, mem_misalign);
      end
      for (int i = 1; i <= d; i++) begin
         @(posedge clk); #1;
         mem_ack = (i == d);
         mem_rdata = (i == d) ? rdata : $urandom;
         @(negedge clk);
         n_cmp++;
         if (mem_req !== 1'b1 || mem_stall !== 1'b1 || mem_we !== rw || mem_rf_le !== 1'b0 ||
             mem_addr !== {exo[7:2], 2'b00} || mem_be !== model_be(rw, size, off) ||
             mem_err !== 1'b0 || (rw && mem_wdata !== model_wdata(size, di))) begin
            n_bad++;
            $display("FAIL %s wait%0d: req=%b stall=%b we=%b rf_le=%b addr=%h be=%b wdata=%h err=%b, expected req=1 stall=1 we=%b rf_le=0 addr=%h be=%b wdata=%h err=0",
                     tag, i, mem_req, mem_stall, mem_we, mem_rf_le, mem_addr, mem_be, mem_wdata, mem_err,
                     rw, {exo[7:2], 2'b00}, model_be(rw, size, off), model_wdata(size, di));
         end
      end
      @(posedge clk); #1;
      mem_ack = junk_ack; mem_rdata = $urandom;
      @(negedge clk);
      exp_out = ld ? model_load(size, off, rdata) : exo;
      n_cmp++;
      if (mem_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
          mem_out !== exp_out || mem_rf_le !== rfle || mem_rd !== rd) begin
         n_bad++;
         $display("FAIL %s done: stall=%b req=%b we=%b out=%h rf_le=%b rd=%0d, expected stall=0 req=0 we=0 out=%h rf_le=%b rd=%0d",
                  tag, mem_stall, mem_req, mem_we, mem_out, mem_rf_le, mem_rd, exp_out, rfle, rd);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ex_out = 32'h0; ex_di = 32'h0; ex_rd = 5'd0; l = 1'b0; rf_le = 1'b0;
      ram_ctrl = 4'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_stall !== 1'b0 || mem_misalign !== 1'b0 ||
          mem_err !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 8'h0 || mem_wdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset: req=%b we=%b stall=%b mis=%b err=%b be=%b addr=%h wdata=%h, expected all zero",
                  mem_req, mem_we, mem_stall, mem_misalign, mem_err, mem_be, mem_addr, mem_wdata);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_directed();
      run_op(1'b0, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 5'd5, 0, 32'h0, 1'b0, "passthru_deadbeef");
      run_op(1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0, 1'b1, 1'b1, 5'd7, 3, 32'h1122_3344, 1'b0, "word_load_10");
      run_op(1'b1, 1'b1, 2'd0, 32'h0000_0013, 32'h0000_00AB, 1'b0, 1'b0, 5'd0, 2, 32'h0, 1'b0, "byte_store_13");
      run_op(1'b1, 1'b0, 2'd1, 32'h0000_0022, 32'h0, 1'b1, 1'b1, 5'd9, 1, 32'hAAAA_8001, 1'b0, "half_load_22");
      run_op(1'b1, 1'b0, 2'd2, 32'h0000_0005, 32'h0, 1'b1, 1'b1, 5'd3, 1, 32'h0, 1'b0, "word_misalign_05");
      run_op(1'b1, 1'b0, 2'd3, 32'h0000_0004, 32'h0, 1'b1, 1'b1, 5'd3, 1, 32'h0, 1'b0, "size11_illegal");
      run_op(1'b1, 1'b1, 2'd1, 32'h0000_0031, 32'h1234_5678, 1'b0, 1'b1, 5'd2, 1, 32'h0, 1'b0, "half_misalign_31");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++)
         run_op(1'b1, 1'b0, 2'd0, 32'h0000_0040 + 32'(k), 32'h0, 1'b1, 1'b1, 5'(k + 1), 1,
                32'hC1C2_C3C4, 1'b1, "b2b_byte_load");
   endtask

   task automatic test_random();
      for (int k = 0; k < 80; k++) begin
         logic e, rw, ld;
         logic [1:0] size;
         e    = ($urandom_range(0, 9) < 7);
         rw   = $urandom_range(0, 1);
         size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         ld   = rw ? 1'b0 : 1'($urandom_range(0, 1));
         run_op(e, rw, size, $urandom, $urandom, ld, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom_range(1, 4), $urandom,
                1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_reset_mid_access();
      @(posedge clk); #1;
      ex_out = 32'h0000_0044; l = 1'b1; rf_le = 1'b1; ram_ctrl = 4'b1010; mem_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_wait_req: req=%b, expected 1", mem_req);
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_req_drop: req=%b, expected 0", mem_req);
      end
      @(posedge clk); #1;
      reset_n = 1'b1; ram_ctrl = 4'h0; ex_out = 32'h5A5A_0000; mem_ack = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || mem_stall !== 1'b0 || mem_out !== 32'h5A5A_0000) begin
         n_bad++;
         $display("FAIL rst_late_ack: req=%b stall=%b out=%h, expected req=0 stall=0 out=5a5a0000",
                  mem_req, mem_stall, mem_out);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || mem_stall !== 1'b0 || mem_out !== 32'h5A5A_0000) begin
         n_bad++;
         $display("FAIL rst_after_ack: req=%b stall=%b out=%h, expected req=0 stall=0 out=5a5a0000",
                  mem_req, mem_stall, mem_out);
      end
   endtask

   task automatic test_long_wait();
      @(posedge clk); #1;
      ex_out = 32'h0000_0080; l = 1'b1; rf_le = 1'b1; ex_rd = 5'd11; ram_ctrl = 4'b1010; mem_ack = 1'b0;
`ifdef MEM_TIMEOUT_EN
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++;
         if (mem_req !== 1'b1 || mem_stall !== 1'b1 || mem_err !== (i == 16)) begin
            n_bad++;
            $display("FAIL timeout_wait%0d: req=%b stall=%b err=%b, expected req=1 stall=1 err=%b",
                     i, mem_req, mem_stall, mem_err, (i == 16));
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || mem_stall !== 1'b0 || mem_err !== 1'b0 ||
          mem_out !== 32'h0 || mem_rf_le !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_done: req=%b stall=%b err=%b out=%h rf_le=%b, expected req=0 stall=0 err=0 out=0 rf_le=0",
                  mem_req, mem_stall, mem_err, mem_out, mem_rf_le);
      end
`else
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         mem_ack = (i == 20);
         mem_rdata = 32'h0BAD_F00D;
         @(negedge clk);
         n_cmp++;
         if (mem_req !== 1'b1 || mem_stall !== 1'b1 || mem_err !== 1'b0) begin
            n_bad++;
            $display("FAIL long_wait%0d: req=%b stall=%b err=%b, expected req=1 stall=1 err=0",
                     i, mem_req, mem_stall, mem_err);
         end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || mem_stall !== 1'b0 || mem_out !== 32'h0BAD_F00D || mem_rf_le !== 1'b1) begin
         n_bad++;
         $display("FAIL long_wait_done: req=%b stall=%b out=%h rf_le=%b, expected req=0 stall=0 out=0badf00d rf_le=1",
                  mem_req, mem_stall, mem_out, mem_rf_le);
      end
`endif
      @(posedge clk); #1;
      ram_ctrl = 4'h0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_access();
      test_long_wait();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
